led_shift_ctrl: RTL and testbench
=================================

Name: led_shift_ctrl

Overview:
- Sequencer for the 8-bit LED shift register; it drives the shifter's mode/data inputs plus a per-step enable strobe.
- On request it serially loads a byte pattern MSB-first, then rotates the register a programmed number of steps, or continuously, at a prescaled step rate.
- Sits between the board-level top and the shifter, replacing manual switch-driven mode/data.

Parameters:
- WIDTH, 8, shifter width and number of load steps.
- DIV, 4, clk cycles per shift step (DIV >= 1; DIV = 1 means one step per cycle).
- ROT_W, 4, width of the rotate-step count.

Ports:
- clk  in  1  global clock.
- rst  in  1  synchronous reset, active-high.
- start_valid  in  1  request to run a new sequence.
- start_ready  out  1  controller can accept a request (high only in IDLE).
- pattern  in  WIDTH  byte to load; sampled on accept.
- rot_count  in  ROT_W  rotate steps after load; 0 = rotate until stop; sampled on accept.
- stop  in  1  abort the running sequence.
- sh_en  out  1  one-cycle shifter step strobe.
- sh_mode  out  1  1 = serial shift-in of sh_data, 0 = rotate.
- sh_data  out  1  serial bit to the shifter.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Shifter contract:
  - Mode 1: q <= {q[WIDTH-2:0], data}.
  - Mode 0: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - Shifter updates only on edges where sh_en is high.
- Reset values:
  - state = IDLE; start_ready = 1; busy = 0; done = 0.
  - sh_en = 0; sh_mode = 0; sh_data = 0.
  - prescaler = 0; step counter = 0; remaining = 0.
  - Reset mid-sequence aborts at that edge: no further sh_en, no done.
- Outputs: all are registered except start_ready and busy, which decode from state.
- States: IDLE, LOAD, ROTATE.
- IDLE:
  - start_valid && start_ready accepts the request: capture pattern into a shadow register and rot_count into remaining.
  - On accept, clear the prescaler and step counter and go to LOAD.
  - stop is ignored in IDLE.
- Prescaler:
  - Runs only in LOAD and ROTATE; counts 0..DIV-1.
  - The edge seeing prescaler == DIV-1 is a step edge; the prescaler returns to 0 on that edge.
  - The first step edge is the DIV-th edge after the accept edge.
- LOAD, on each step edge:
  - sh_en <= 1, sh_mode <= 1, sh_data <= shadow[WIDTH-1]; shadow shifts left by 1; step counter increments.
  - On the step edge issuing the WIDTH-th bit: if remaining != 0 or rot_count was 0, go to ROTATE.
  - After WIDTH steps the shifter holds pattern exactly.
- ROTATE, on each step edge:
  - sh_en <= 1, sh_mode <= 0, sh_data <= 0.
  - Counted mode: remaining decrements. The edge issuing the last step (remaining == 1) also sets done <= 1 and moves to IDLE.
  - Continuous mode (captured count 0): never self-terminates.
- Between step edges: sh_en = 0, sh_data = 0; sh_mode holds its last value.
- stop in LOAD/ROTATE:
  - At that edge go to IDLE; sh_en = 0 (stop beats a coincident step edge); done = 0.
  - The shifter keeps its partial contents.
- Step counts:
  - Counted sequence: exactly WIDTH + rot_count sh_en pulses.
  - Continuous sequence: WIDTH pulses, then one every DIV cycles until stop.
- start_valid while busy: start_ready = 0, request not accepted; the requester holds valid.
- Back-to-back starts: done and a new accept can occur on consecutive edges; no dead cycle is required beyond the IDLE cycle.
- rot_count = max (2^ROT_W - 1): no wrap; remaining is a down-counter loaded once.

Test Plan:
- Reset/idle: assert rst for 2 cycles mid-run → next cycle sh_en = 0, done = 0, busy = 0, start_ready = 1; with no start, sh_en stays 0 for 50 cycles.
- Basic load, DIV = 4, pattern = 8'hA5, rot_count = 0, stop 40 cycles after accept:
  - First sh_en 4 cycles after the accept edge, then one every 4 cycles.
  - sh_mode = 1 and sh_data sequence 1,0,1,0,0,1,0,1 on the first 8 pulses.
  - Shifter model q = 8'hA5 after pulse 8.
- Counted rotate, DIV = 1, pattern = 8'h81, rot_count = 3:
  - 11 consecutive sh_en pulses; pulses 9–11 have sh_mode = 0.
  - Final q = 8'h0C.
  - done high exactly on the cycle of pulse 11; busy low the next cycle.
- Stop collision, DIV = 2: assert stop on a step edge during LOAD after 3 pulses → no 4th pulse, done = 0, state IDLE, start_ready = 1 next cycle.
- Handshake:
  - start_valid held during a busy sequence → not accepted; accepted on the first IDLE cycle with its own pattern 8'h3C.
  - Second start presented in the done cycle is accepted one cycle later.
- Continuous, DIV = 3, pattern = 8'h01, rot_count = 0 → q cycles 01,02,04,…,80,01 every 3 cycles; done never pulses until stop.

Source files
------------

// File: rtl/led_shift_ctrl_if.sv
// led_shift_ctrl_if: request handshake and shifter drive bundle for the LED shift sequencer.
interface led_shift_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int ROT_W = 4
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] pattern;
  logic [ROT_W-1:0] rot_count;
  logic             stop;
  logic             sh_en;
  logic             sh_mode;
  logic             sh_data;
  logic             busy;
  logic             done;
  modport master (
    output start_valid, pattern, rot_count, stop,
    input  start_ready, sh_en, sh_mode, sh_data, busy, done
  );
  modport slave (
    input  start_valid, pattern, rot_count, stop,
    output start_ready, sh_en, sh_mode, sh_data, busy, done
  );
endinterface

// File: rtl/led_shift_ctrl.sv
// led_shift_ctrl: loads a byte MSB-first into the LED shifter, then rotates it a
// counted number of steps (or until stop) at one step every DIV clocks.
module led_shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4,
  parameter int ROT_W = 4
) (
  input logic             clk,
  input logic             rst,
  led_shift_ctrl_if.slave ctrl
);
  typedef enum logic [1:0] {IDLE, LOAD, ROTATE} state_t;
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW = $clog2(WIDTH) + 1;
  state_t           state_q;
  logic [PW-1:0]    presc_q;
  logic [SW-1:0]    step_q;
  logic [ROT_W-1:0] rem_q;
  logic [WIDTH-1:0] shadow_q;
  logic             sh_en_q, sh_mode_q, sh_data_q, done_q;
  logic             step_edge, loading;
  assign loading          = state_q == LOAD;
  assign step_edge        = state_q != IDLE && presc_q == PW'(DIV - 1);
  assign ctrl.start_ready = state_q == IDLE;
  assign ctrl.busy        = state_q != IDLE;
  assign ctrl.sh_en       = sh_en_q;
  assign ctrl.sh_mode     = sh_mode_q;
  assign ctrl.sh_data     = sh_data_q;
  assign ctrl.done        = done_q;
  // A captured rot_count of 0 leaves rem_q at 0, which marks continuous rotation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      step_q    <= '0;
      rem_q     <= '0;
      shadow_q  <= '0;
      sh_en_q   <= 1'b0;
      sh_mode_q <= 1'b0;
      sh_data_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sh_en_q   <= 1'b0;
      sh_data_q <= 1'b0;
      done_q    <= 1'b0;
      if (state_q == IDLE) begin
        if (ctrl.start_valid) begin
          shadow_q <= ctrl.pattern;
          rem_q    <= ctrl.rot_count;
          presc_q  <= '0;
          step_q   <= '0;
          state_q  <= LOAD;
        end
      end else if (ctrl.stop) begin
        state_q <= IDLE;
      end else begin
        presc_q <= step_edge ? '0 : presc_q + 1'b1;
        if (step_edge) begin
          sh_en_q   <= 1'b1;
          sh_mode_q <= loading;
          sh_data_q <= loading & shadow_q[WIDTH-1];
          if (loading) begin
            shadow_q <= {shadow_q[WIDTH-2:0], 1'b0};
            step_q   <= step_q + 1'b1;
            if (step_q == SW'(WIDTH - 1)) state_q <= ROTATE;
          end else if (rem_q != '0) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == ROT_W'(1)) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_led_shift_ctrl.sv
// tb_led_shift_ctrl: drives four controllers (DIV = 1..4) and checks their step
// schedule and the resulting shifter contents against an arithmetic model.
module tb_led_shift_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic       sv = 1'b0, stp = 1'b0;
  logic [7:0] pat = '0;
  logic [3:0] rc = '0;
  int         sel = 4;
  int         errors = 0, checks = 0;
  logic [7:0] q = '0;
  led_shift_ctrl_if #(.WIDTH(8), .ROT_W(4)) if1 (), if2 (), if3 (), if4 ();
  led_shift_ctrl #(.WIDTH(8), .DIV(1), .ROT_W(4)) u1 (.clk(clk), .rst(rst), .ctrl(if1));
  led_shift_ctrl #(.WIDTH(8), .DIV(2), .ROT_W(4)) u2 (.clk(clk), .rst(rst), .ctrl(if2));
  led_shift_ctrl #(.WIDTH(8), .DIV(3), .ROT_W(4)) u3 (.clk(clk), .rst(rst), .ctrl(if3));
  led_shift_ctrl #(.WIDTH(8), .DIV(4), .ROT_W(4)) u4 (.clk(clk), .rst(rst), .ctrl(if4));
  assign if1.start_valid = sv && sel == 1;
  assign if2.start_valid = sv && sel == 2;
  assign if3.start_valid = sv && sel == 3;
  assign if4.start_valid = sv && sel == 4;
  assign if1.stop = stp && sel == 1;
  assign if2.stop = stp && sel == 2;
  assign if3.stop = stp && sel == 3;
  assign if4.stop = stp && sel == 4;
  assign if1.pattern = pat;
  assign if2.pattern = pat;
  assign if3.pattern = pat;
  assign if4.pattern = pat;
  assign if1.rot_count = rc;
  assign if2.rot_count = rc;
  assign if3.rot_count = rc;
  assign if4.rot_count = rc;
  logic [5:0] o1, o2, o3, o4, o;
  assign o1 = {if1.start_ready, if1.busy, if1.done, if1.sh_en, if1.sh_mode, if1.sh_data};
  assign o2 = {if2.start_ready, if2.busy, if2.done, if2.sh_en, if2.sh_mode, if2.sh_data};
  assign o3 = {if3.start_ready, if3.busy, if3.done, if3.sh_en, if3.sh_mode, if3.sh_data};
  assign o4 = {if4.start_ready, if4.busy, if4.done, if4.sh_en, if4.sh_mode, if4.sh_data};
  assign o  = sel == 1 ? o1 : sel == 2 ? o2 : sel == 3 ? o3 : o4;
  logic c_ready, c_busy, c_done, c_en, c_mode, c_data;
  assign {c_ready, c_busy, c_done, c_en, c_mode, c_data} = o;
  // Downstream shifter as described by its contract.
  always @(posedge clk) if (c_en) q <= c_mode ? {q[6:0], c_data} : {q[6:0], q[7]};
  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    for (int i = 0; i < n % 8; i++) v = {v[6:0], v[7]};
    return v;
  endfunction
  // One sequence on DUT d: pulse k lands k*d edges after accept; stop at edge s kills edges >= s.
  task automatic run_seq(input int d, input logic [7:0] p, input logic [3:0] r, input int s,
                         input int n, input bit chained, input bit hold, input logic [7:0] next_p);
    int total, k, m, lim;
    logic e_en, e_data, e_done, e_busy;
    sel = d;
    if (!chained) begin
      @(negedge clk);
      for (int i = 0; i < 40 && !c_ready; i++) @(negedge clk);
    end
    checks++;
    if (c_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_start: start_ready=%b expected 1", c_ready);
    end
    sv = 1'b1; pat = p; rc = r;
    @(negedge clk);
    sv = 1'b0;
    checks++;
    if (c_busy !== 1'b1 || c_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept: busy=%b start_ready=%b expected 1 0", c_busy, c_ready);
    end
    total = r == 0 ? (1 << 20) : 8 + int'(r);
    lim = s == 0 ? total : (s - 1) / d;
    if (lim > total) lim = total;
    for (int t = 1; t <= n; t++) begin
      stp = t == s;
      if (hold && t >= 2) begin sv = 1'b1; pat = next_p; end
      @(negedge clk);
      k = t / d;
      e_en = t % d == 0 && k >= 1 && k <= lim;
      e_data = (e_en && k <= 8) ? p[8-k] : 1'b0;
      e_done = r != 0 && t == total * d && (s == 0 || t < s);
      e_busy = t < ((s != 0 && s <= total * d) ? s : total * d);
      checks++;
      if ({c_en, c_data, c_done, c_busy, c_ready} !== {e_en, e_data, e_done, e_busy, !e_busy}) begin
        errors++;
        $display("FAIL seq d=%0d p=%h r=%0d t=%0d: en,data,done,busy,ready=%b%b%b%b%b expected %b%b%b%b%b",
                 d, p, r, t, c_en, c_data, c_done, c_busy, c_ready, e_en, e_data, e_done, e_busy, !e_busy);
      end
      if (e_en) begin
        checks++;
        if (c_mode !== (k <= 8)) begin
          errors++;
          $display("FAIL mode d=%0d t=%0d pulse=%0d: sh_mode=%b expected %b", d, t, k, c_mode, k <= 8);
        end
      end
      m = (t - 1) / d;
      if (m > lim) m = lim;
      if (m >= 8) begin
        checks++;
        if (q !== rotl(p, m - 8)) begin
          errors++;
          $display("FAIL shifter d=%0d t=%0d pulses=%0d: q=%h expected %h", d, t, m, q, rotl(p, m - 8));
        end
      end
    end
    stp = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({c_ready, c_busy, c_done, c_en, c_mode, c_data} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_state: ready,busy,done,en,mode,data=%b expected 100000",
               {c_ready, c_busy, c_done, c_en, c_mode, c_data});
    end
    run_seq(4, 8'h5A, 4'd0, 0, 14, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({c_ready, c_busy, c_done, c_en, c_mode, c_data} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_midrun: ready,busy,done,en,mode,data=%b expected 100000",
               {c_ready, c_busy, c_done, c_en, c_mode, c_data});
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (c_en !== 1'b0 || c_busy !== 1'b0 || c_done !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet cycle=%0d: en=%b busy=%b done=%b expected 0 0 0", i, c_en, c_busy, c_done);
      end
    end
  endtask
  task automatic test_basic_load();
    run_seq(4, 8'hA5, 4'd0, 40, 44, 1'b0, 1'b0, 8'h00);
  endtask
  task automatic test_counted();
    run_seq(1, 8'h81, 4'd3, 0, 13, 1'b0, 1'b0, 8'h00);
    run_seq(1, 8'hC3, 4'd15, 0, 25, 1'b0, 1'b0, 8'h00);
  endtask
  task automatic test_stop_collision();
    run_seq(2, 8'hF0, 4'd5, 8, 12, 1'b0, 1'b0, 8'h00);
  endtask
  task automatic test_back_to_back();
    run_seq(1, 8'h96, 4'd2, 0, 10, 1'b0, 1'b1, 8'h3C);
    run_seq(1, 8'h3C, 4'd1, 0, 9, 1'b1, 1'b1, 8'h5B);
    run_seq(1, 8'h5B, 4'd4, 0, 14, 1'b1, 1'b0, 8'h00);
  endtask
  task automatic test_continuous();
    run_seq(3, 8'h01, 4'd0, 3 * 8 + 3 * 12 + 2, 3 * 8 + 3 * 12 + 6, 1'b0, 1'b0, 8'h00);
  endtask
  task automatic test_random();
    int d, s, n;
    logic [7:0] p;
    logic [3:0] r;
    for (int i = 0; i < 10; i++) begin
      d = $urandom_range(1, 4);
      p = 8'($urandom);
      r = 4'($urandom_range(0, 15));
      if (r == 0) s = 8 * d + $urandom_range(1, 30);
      else s = $urandom_range(0, 2) == 0 ? $urandom_range(1, (8 + int'(r)) * d) : 0;
      n = s != 0 ? s + 3 : (8 + int'(r)) * d + 2;
      run_seq(d, p, r, s, n, 1'b0, 1'b0, 8'h00);
    end
  endtask
  initial begin
    test_reset();
    test_basic_load();
    test_counted();
    test_stop_collision();
    test_back_to_back();
    test_continuous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
